// File: rtl/palette_dac_pkg.sv
// Shared types and colour helpers for the second-generation palette DAC.
// Covers colour-mode decoding, the arbiter state set and the brightness fade multiply.
package palette_dac_pkg;

  typedef enum logic [1:0] {
    MODE_444    = 2'd0,
    MODE_555    = 2'd1,
    MODE_555MIX = 2'd2,
    MODE_565    = 2'd3
  } colour_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    POSTED = 2'd2,
    DRAIN  = 2'd3
  } arb_state_e;

  // Returns {r8, g8, b8}; short channels replicate their MSBs into the low bits.
  function automatic logic [23:0] expand_colour(input colour_mode_e mode, input logic [15:0] w);
    logic [7:0] r, g, b;
    r = '0;
    g = '0;
    b = '0;
    case (mode)
      MODE_444: begin
        r = {w[15:12], w[15:12]};
        g = {w[11:8], w[11:8]};
        b = {w[7:4], w[7:4]};
      end
      MODE_555: begin
        r = {w[14:10], w[14:12]};
        g = {w[9:5], w[9:7]};
        b = {w[4:0], w[4:2]};
      end
      MODE_555MIX: begin
        r = {w[15:12], w[3], w[15:13]};
        g = {w[11:8], w[2], w[11:9]};
        b = {w[7:4], w[1], w[7:5]};
      end
      MODE_565: begin
        r = {w[15:11], w[15:13]};
        g = {w[10:5], w[10:9]};
        b = {w[4:0], w[4:2]};
      end
      default: ;
    endcase
    return {r, g, b};
  endfunction

  // Level 255 multiplies by 256 and so passes the channel through unchanged.
  function automatic logic [7:0] apply_bright(input logic [7:0] c8, input logic [7:0] level);
    logic [15:0] prod;
    prod = 16'(c8) * (16'(level) + 16'd1);
    return prod[15:8];
  endfunction

endpackage

// File: rtl/palette_dac_gen2_arbiter.sv
// CPU/video arbiter for palette RAM: owns the access FSM, the one-entry posted
// write buffer, dtack generation and the RAM address/data/strobe mux.
module palette_cpu_arbiter
  import palette_dac_pkg::*;
#(
  parameter int PAL_AW = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce_double,
  input  logic              busy,
  input  logic              cpu_cs,
  input  logic [PAL_AW-1:0] cpu_addr,
  input  logic [15:0]       cpu_din,
  input  logic              cpu_rw_n,
  input  logic              cpu_uds_n,
  input  logic              cpu_lds_n,
  input  logic [PAL_AW-1:0] pix_idx,
  output logic              cpu_dtack_n,
  output logic [PAL_AW-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  output logic              ram_we_l_n,
  output logic              ram_we_h_n,
  output arb_state_e        state
);

  arb_state_e        state_nxt;
  logic              buf_full;
  logic              buf_set;
  logic              buf_clr;
  logic [PAL_AW-1:0] buf_addr;
  logic [15:0]       buf_data;
  logic [1:0]        buf_lanes;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      buf_full <= 1'b0;
    end else begin
      state <= state_nxt;
      if (buf_set)      buf_full <= 1'b1;
      else if (buf_clr) buf_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_set) begin
      buf_addr  <= cpu_addr;
      buf_data  <= cpu_din;
      buf_lanes <= {~cpu_uds_n, ~cpu_lds_n};
    end
  end

  always_comb begin
    state_nxt   = state;
    buf_set     = 1'b0;
    buf_clr     = 1'b0;
    ram_addr    = pix_idx;
    ram_wdata   = cpu_din;
    ram_we_l_n  = 1'b1;
    ram_we_h_n  = 1'b1;
    cpu_dtack_n = 1'b1;

    // Draining before granting keeps a following read coherent with the posted write.
    if (ce_double) begin
      case (state)
        IDLE: begin
          if (buf_full && !busy) begin
            state_nxt = DRAIN;
          end else if (cpu_cs && !busy) begin
            state_nxt = ACCESS;
          end else if (cpu_cs && !cpu_rw_n && busy && !buf_full) begin
            buf_set   = 1'b1;
            state_nxt = POSTED;
          end
        end
        DRAIN: begin
          buf_clr   = 1'b1;
          state_nxt = IDLE;
        end
        ACCESS, POSTED: begin
          if (!cpu_cs) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end

    case (state)
      DRAIN: begin
        ram_addr   = buf_addr;
        ram_wdata  = buf_data;
        ram_we_l_n = ~buf_lanes[0];
        ram_we_h_n = ~buf_lanes[1];
      end
      ACCESS: begin
        ram_addr    = cpu_addr;
        ram_we_l_n  = cpu_rw_n | cpu_lds_n;
        ram_we_h_n  = cpu_rw_n | cpu_uds_n;
        cpu_dtack_n = ~cpu_cs;
      end
      POSTED: cpu_dtack_n = ~cpu_cs;
      default: ;
    endcase
  end

endmodule

// File: rtl/palette_dac_gen2.sv
// Palette DAC top: blank delay pipes, palette word pipeline aligned to the blanks,
// colour expansion with brightness fade, and the CPU arbiter instance.
module palette_dac_gen2
  import palette_dac_pkg::*;
#(
  parameter int PAL_AW    = 14,
  parameter int BLANK_DLY = 3,
  parameter bit BRIGHT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce_pixel,
  input  logic              ce_double,
  input  logic [1:0]        mode,
  input  logic [7:0]        brightness,
  input  logic              acc_mode,
  input  logic              cpu_cs,
  input  logic [PAL_AW-1:0] cpu_addr,
  input  logic [15:0]       cpu_din,
  output logic [15:0]       cpu_dout,
  input  logic              cpu_rw_n,
  input  logic              cpu_uds_n,
  input  logic              cpu_lds_n,
  output logic              cpu_dtack_n,
  input  logic              hblank_n,
  input  logic              vblank_n,
  output logic              o_hblank_n,
  output logic              o_vblank_n,
  input  logic [PAL_AW-1:0] pix_idx,
  output logic [7:0]        video_r,
  output logic [7:0]        video_g,
  output logic [7:0]        video_b,
  output logic [PAL_AW-1:0] ram_addr,
  input  logic [15:0]       ram_rdata,
  output logic [15:0]       ram_wdata,
  output logic              ram_we_l_n,
  output logic              ram_we_h_n
);

  logic [BLANK_DLY-1:0] hb_pipe;
  logic [BLANK_DLY-1:0] vb_pipe;
  logic [15:0]          word_p [BLANK_DLY-1];
  logic [BLANK_DLY-2:0] vld_p;
  arb_state_e           arb_state;
  logic                 idle_d;
  logic                 slot_ok;
  logic                 busy;
  logic [23:0]          rgb_exp;
  logic [23:0]          rgb_shaded;

  assign busy       = ~acc_mode & hblank_n & vblank_n & (&hb_pipe) & (&vb_pipe);
  assign o_hblank_n = hb_pipe[BLANK_DLY-1];
  assign o_vblank_n = vb_pipe[BLANK_DLY-1];
  assign cpu_dout   = ram_rdata;

  // ram_rdata reflects the address of the previous clock, so the slot is a
  // pixel fetch only if the arbiter was idle then and is still idle now.
  assign slot_ok = (arb_state == IDLE) && idle_d;

  palette_cpu_arbiter #(.PAL_AW(PAL_AW)) u_arbiter (
    .clk         (clk),
    .reset_n     (reset_n),
    .ce_double   (ce_double),
    .busy        (busy),
    .cpu_cs      (cpu_cs),
    .cpu_addr    (cpu_addr),
    .cpu_din     (cpu_din),
    .cpu_rw_n    (cpu_rw_n),
    .cpu_uds_n   (cpu_uds_n),
    .cpu_lds_n   (cpu_lds_n),
    .pix_idx     (pix_idx),
    .cpu_dtack_n (cpu_dtack_n),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_we_l_n  (ram_we_l_n),
    .ram_we_h_n  (ram_we_h_n),
    .state       (arb_state)
  );

  // Stage p0..p(BLANK_DLY-2): blank flags, palette word and slot-valid advance together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hb_pipe <= '0;
      vb_pipe <= '0;
      vld_p   <= '0;
      idle_d  <= 1'b0;
    end else begin
      idle_d <= (arb_state == IDLE);
      if (ce_pixel) begin
        hb_pipe  <= {hb_pipe[BLANK_DLY-2:0], hblank_n};
        vb_pipe  <= {vb_pipe[BLANK_DLY-2:0], vblank_n};
        vld_p[0] <= slot_ok;
        for (int i = 1; i < BLANK_DLY - 1; i++) vld_p[i] <= vld_p[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ce_pixel) begin
      word_p[0] <= ram_rdata;
      for (int i = 1; i < BLANK_DLY - 1; i++) word_p[i] <= word_p[i-1];
    end
  end

  always_comb begin
    rgb_exp = expand_colour(colour_mode_e'(mode), word_p[BLANK_DLY-2]);
    if (BRIGHT_EN) begin
      rgb_shaded = {apply_bright(rgb_exp[23:16], brightness),
                    apply_bright(rgb_exp[15:8], brightness),
                    apply_bright(rgb_exp[7:0], brightness)};
    end else begin
      rgb_shaded = rgb_exp;
    end
  end

  // Output stage: loads with the last blank stage so colour and o_*blank_n stay aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {video_r, video_g, video_b} <= '0;
    end else if (ce_pixel) begin
      if (hb_pipe[BLANK_DLY-2] && vb_pipe[BLANK_DLY-2]) begin
        if (vld_p[BLANK_DLY-2]) {video_r, video_g, video_b} <= rgb_shaded;
      end else begin
        {video_r, video_g, video_b} <= '0;
      end
    end
  end

endmodule

// File: tb/tb_palette_dac_gen2.sv
// Self-checking bench for palette_dac_gen2 with a behavioural palette RAM and
// scoreboard queues for CPU read data and pixel colours.
module tb_palette_dac_gen2;
  localparam int PAL_AW    = 14;
  localparam int BLANK_DLY = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0]        cnt = 2'd0;
  logic              ce_pixel, ce_double;
  logic [1:0]        mode;
  logic [7:0]        brightness;
  logic              acc_mode, cpu_cs, cpu_rw_n, cpu_uds_n, cpu_lds_n;
  logic              hblank_n, vblank_n;
  logic [PAL_AW-1:0] cpu_addr, pix_idx, ram_addr;
  logic [15:0]       cpu_din, cpu_dout, ram_rdata, ram_wdata;
  logic              cpu_dtack_n, o_hblank_n, o_vblank_n, ram_we_l_n, ram_we_h_n;
  logic [7:0]        video_r, video_g, video_b;

  int errors = 0;
  int checks = 0;
  logic [15:0] rd_q[$];
  logic [23:0] pix_q[$];

  logic [15:0]       mem [0:(1<<PAL_AW)-1];
  int                strobe_cnt = 0;
  int                both_cnt = 0;
  logic [PAL_AW-1:0] last_waddr;
  logic [15:0]       last_wdata;

  palette_dac_gen2 #(.PAL_AW(PAL_AW), .BLANK_DLY(BLANK_DLY), .BRIGHT_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .ce_pixel(ce_pixel), .ce_double(ce_double),
    .mode(mode), .brightness(brightness), .acc_mode(acc_mode),
    .cpu_cs(cpu_cs), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .cpu_rw_n(cpu_rw_n), .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n),
    .cpu_dtack_n(cpu_dtack_n), .hblank_n(hblank_n), .vblank_n(vblank_n),
    .o_hblank_n(o_hblank_n), .o_vblank_n(o_vblank_n), .pix_idx(pix_idx),
    .video_r(video_r), .video_g(video_g), .video_b(video_b),
    .ram_addr(ram_addr), .ram_rdata(ram_rdata), .ram_wdata(ram_wdata),
    .ram_we_l_n(ram_we_l_n), .ram_we_h_n(ram_we_h_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 2'd1;
  assign ce_double = cnt[0];
  assign ce_pixel  = &cnt;

  always @(posedge clk) begin
    if (!ram_we_l_n) mem[ram_addr][7:0]  <= ram_wdata[7:0];
    if (!ram_we_h_n) mem[ram_addr][15:8] <= ram_wdata[15:8];
    ram_rdata <= mem[ram_addr];
    if (!ram_we_l_n || !ram_we_h_n) begin
      strobe_cnt <= strobe_cnt + 1;
      last_waddr <= ram_addr;
      last_wdata <= ram_wdata;
      if (!ram_we_l_n && !ram_we_h_n) both_cnt <= both_cnt + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_access(input logic rw_n, input logic [PAL_AW-1:0] addr,
                            input logic [15:0] din, input int max_clk,
                            output logic acked, output logic [15:0] dout);
    cpu_cs = 1'b1; cpu_rw_n = rw_n; cpu_addr = addr; cpu_din = din;
    cpu_uds_n = 1'b0; cpu_lds_n = 1'b0;
    acked = 1'b0; dout = '0;
    for (int i = 0; i < max_clk; i++) begin
      @(negedge clk);
      if (!cpu_dtack_n) begin acked = 1'b1; break; end
    end
    if (acked) begin @(negedge clk); dout = cpu_dout; end
    cpu_cs = 1'b0; cpu_rw_n = 1'b1;
    tick(4);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(3);
    checks++; if (o_hblank_n !== 1'b0 || o_vblank_n !== 1'b0) begin errors++; $display("FAIL reset_blank got %b%b want 00", o_hblank_n, o_vblank_n); end
    checks++; if ({video_r, video_g, video_b} !== 24'h0) begin errors++; $display("FAIL reset_video got %h want 000000", {video_r, video_g, video_b}); end
    checks++; if (cpu_dtack_n !== 1'b1) begin errors++; $display("FAIL reset_dtack got %b want 1", cpu_dtack_n); end
    checks++; if ({ram_we_h_n, ram_we_l_n} !== 2'b11) begin errors++; $display("FAIL reset_strobes got %b want 11", {ram_we_h_n, ram_we_l_n}); end
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_reset_mid_posted();
    logic ack; logic [15:0] d; int s0; logic [15:0] want;
    hblank_n = 1'b0;
    cpu_access(1'b0, 14'h0010, 16'hBEEF, 20, ack, d);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL preload_ack got %b want 1", ack); end
    hblank_n = 1'b1; vblank_n = 1'b1;
    tick(20);
    s0 = strobe_cnt;
    cpu_cs = 1'b1; cpu_rw_n = 1'b0; cpu_addr = 14'h0010; cpu_din = 16'h1234;
    ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!cpu_dtack_n) begin ack = 1'b1; break; end
    end
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL posted_ack got %b want 1", ack); end
    reset_n = 1'b0;
    tick(1);
    cpu_cs = 1'b0; cpu_rw_n = 1'b1; hblank_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    cpu_cs = 1'b1; cpu_rw_n = 1'b1; cpu_addr = 14'h0010;
    rd_q.push_back(16'hBEEF);
    #1;
    checks++; if (cpu_dtack_n !== 1'b1) begin errors++; $display("FAIL read_not_yet_granted got %b want 1", cpu_dtack_n); end
    ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!cpu_dtack_n) begin ack = 1'b1; break; end
    end
    @(negedge clk);
    d = cpu_dout;
    cpu_cs = 1'b0;
    tick(4);
    want = rd_q.pop_front();
    checks++; if (!ack || d !== want) begin errors++; $display("FAIL read_after_reset ack=%b got %h want %h", ack, d, want); end
    checks++; if (strobe_cnt !== s0) begin errors++; $display("FAIL posted_discarded strobes got %0d want %0d", strobe_cnt, s0); end
  endtask

  task automatic test_posted_write();
    logic ack; int s0, b0; logic seen;
    hblank_n = 1'b1; vblank_n = 1'b1;
    tick(20);
    s0 = strobe_cnt; b0 = both_cnt;
    cpu_cs = 1'b1; cpu_rw_n = 1'b0; cpu_addr = 14'h0020; cpu_din = 16'hF0A5;
    ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!cpu_dtack_n) begin ack = 1'b1; break; end
    end
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL posted_dtack_2cd got %b want 1", ack); end
    cpu_cs = 1'b0; cpu_rw_n = 1'b1;
    tick(12);
    checks++; if (strobe_cnt !== s0) begin errors++; $display("FAIL no_strobe_active got %0d want %0d", strobe_cnt - s0, 0); end
    hblank_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (strobe_cnt != s0) begin seen = 1'b1; break; end
    end
    tick(6);
    checks++; if (!seen || strobe_cnt - s0 != 2) begin errors++; $display("FAIL drain_len seen=%b got %0d want 2", seen, strobe_cnt - s0); end
    checks++; if (both_cnt - b0 != 2) begin errors++; $display("FAIL drain_both_lanes got %0d want 2", both_cnt - b0); end
    checks++; if (last_waddr !== 14'h0020 || last_wdata !== 16'hF0A5) begin errors++; $display("FAIL drain_addr_data got %h/%h want 0020/f0a5", last_waddr, last_wdata); end
  endtask

  task automatic test_raw_coherence();
    logic ack, early; logic [15:0] d, want;
    hblank_n = 1'b1;
    tick(20);
    cpu_cs = 1'b1; cpu_rw_n = 1'b0; cpu_addr = 14'h0040; cpu_din = 16'hF0A5;
    ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!cpu_dtack_n) begin ack = 1'b1; break; end
    end
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL raw_post_ack got %b want 1", ack); end
    cpu_cs = 1'b0; cpu_rw_n = 1'b1;
    tick(2);
    cpu_cs = 1'b1; cpu_rw_n = 1'b1; cpu_addr = 14'h0040;
    rd_q.push_back(16'hF0A5);
    early = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (!cpu_dtack_n) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL read_stalls got early=%b want 0", early); end
    hblank_n = 1'b0;
    ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!cpu_dtack_n) begin ack = 1'b1; break; end
    end
    @(negedge clk);
    d = cpu_dout;
    cpu_cs = 1'b0;
    tick(4);
    want = rd_q.pop_front();
    checks++; if (!ack || d !== want) begin errors++; $display("FAIL raw_data ack=%b got %h want %h", ack, d, want); end
  endtask

  typedef struct packed {
    logic [1:0]        m;
    logic [PAL_AW-1:0] idx;
    logic [7:0]        br;
    logic [23:0]       rgb;
  } colour_case_t;

  task automatic test_colour_modes();
    logic a1, a2; logic [15:0] d; logic [23:0] want;
    colour_case_t tbl [8];
    tbl[0] = '{2'd3, 14'h0100, 8'd255, 24'hFFFFFF};
    tbl[1] = '{2'd3, 14'h0100, 8'd127, 24'h7F7F7F};
    tbl[2] = '{2'd3, 14'h0100, 8'd0,   24'h000000};
    tbl[3] = '{2'd2, 14'h0101, 8'd255, 24'h844221};
    tbl[4] = '{2'd0, 14'h0101, 8'd255, 24'h884422};
    tbl[5] = '{2'd3, 14'h0101, 8'd255, 24'h848608};
    tbl[6] = '{2'd1, 14'h0101, 8'd255, 24'h080808};
    tbl[7] = '{2'd0, 14'h0101, 8'd127, 24'h442211};
    hblank_n = 1'b0;
    cpu_access(1'b0, 14'h0100, 16'hFFFF, 20, a1, d);
    cpu_access(1'b0, 14'h0101, 16'h8421, 20, a2, d);
    checks++; if (!(a1 && a2)) begin errors++; $display("FAIL pal_preload got %b%b want 11", a1, a2); end
    acc_mode = 1'b0;
    hblank_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mode = tbl[i].m; pix_idx = tbl[i].idx; brightness = tbl[i].br;
      pix_q.push_back(tbl[i].rgb);
      tick(20);
      want = pix_q.pop_front();
      checks++; if ({video_r, video_g, video_b} !== want) begin errors++; $display("FAIL colour[%0d] got %h want %h", i, {video_r, video_g, video_b}, want); end
    end
    hblank_n = 1'b0;
    tick(20);
    checks++; if ({video_r, video_g, video_b} !== 24'h0) begin errors++; $display("FAIL blank_black got %h want 000000", {video_r, video_g, video_b}); end
  endtask

  task automatic test_acc_mode_hold();
    logic ack, found; int n, bad, n_pix; logic [15:0] d, want;
    mode = 2'd3; pix_idx = 14'h0100; brightness = 8'd255; acc_mode = 1'b0;
    hblank_n = 1'b1;
    tick(24);
    checks++; if ({video_r, video_g, video_b} !== 24'hFFFFFF) begin errors++; $display("FAIL hold_pre got %h want ffffff", {video_r, video_g, video_b}); end
    acc_mode = 1'b1;
    cpu_cs = 1'b1; cpu_rw_n = 1'b1; cpu_addr = 14'h0020;
    rd_q.push_back(16'hF0A5);
    ack = 1'b0; n = 0; bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n++;
      if ({video_r, video_g, video_b} !== 24'hFFFFFF) bad++;
      if (!cpu_dtack_n) begin ack = 1'b1; break; end
    end
    checks++; if (!ack || n > 2) begin errors++; $display("FAIL acc_grant ack=%b got %0d clk want <=2", ack, n); end
    @(negedge clk);
    d = cpu_dout;
    repeat (12) begin
      @(negedge clk);
      if ({video_r, video_g, video_b} !== 24'hFFFFFF) bad++;
    end
    cpu_cs = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if ({video_r, video_g, video_b} !== 24'hFFFFFF) bad++;
    end
    want = rd_q.pop_front();
    checks++; if (d !== want) begin errors++; $display("FAIL acc_read got %h want %h", d, want); end
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_video got %0d bad samples want 0", bad); end
    acc_mode = 1'b0;
    tick(4);
    hblank_n = 1'b0;
    n_pix = 0; found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ce_pixel) n_pix++;
      @(negedge clk);
      if (!o_hblank_n) begin found = 1'b1; break; end
    end
    checks++; if (!found || n_pix != BLANK_DLY) begin errors++; $display("FAIL hblank_lag found=%b got %0d want %0d", found, n_pix, BLANK_DLY); end
    checks++; if ({video_r, video_g, video_b} !== 24'h0) begin errors++; $display("FAIL video_aligned_blank got %h want 000000", {video_r, video_g, video_b}); end
  endtask

  initial begin
    mode = 2'd0; brightness = 8'd255; acc_mode = 1'b0;
    cpu_cs = 1'b0; cpu_rw_n = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
    cpu_addr = '0; cpu_din = '0; pix_idx = '0;
    hblank_n = 1'b0; vblank_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_reset_mid_posted();
    test_posted_write();
    test_raw_coherence();
    test_colour_modes();
    test_acc_mode_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
